// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests words from instruction memory at pc, holds one
// captured instruction for decode, and stops fetching once a halt opcode is captured.
module fetch_unit #(
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        redirect,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned OP_LSB = WORD_W - OP_W;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state, next_state;
  logic              buf_free;
  logic              accept;
  logic              consume;
  logic              flush;
  logic              is_halt_op;
  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] instr_pc_q;
  logic              valid_q;
  logic              halted_q;
  logic [WORD_W-1:0] count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= next_state;
  end

  // Next state plus the combinational memory-side handshake (pc_en, iREN, iaddr).
  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    iaddr      = '0;
    pc_en      = 1'b0;
    accept     = 1'b0;
    consume    = 1'b0;
    flush      = 1'b0;
    buf_free   = !valid_q || dec_ready;
    is_halt_op = (iload[WORD_W-1:OP_LSB] == HALT_OP);

    unique case (state)
      FETCH: begin
        if (redirect) begin
          flush = 1'b1;
        end else begin
          iREN  = 1'b1;
          iaddr = pc;
          if (ihit && buf_free) begin
            accept = 1'b1;
            pc_en  = 1'b1;
            if (is_halt_op) next_state = HALT;
          end else if (ihit) begin
            next_state = HOLD;
          end else begin
            consume = valid_q && dec_ready;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          flush      = 1'b1;
          next_state = FETCH;
        end else if (dec_ready) begin
          consume    = valid_q;
          next_state = FETCH;
        end
      end
      HALT: begin
        consume = valid_q && dec_ready;
      end
      default: next_state = FETCH;
    endcase

    // Reset must silence the memory port even though the state sits in FETCH.
    if (!nRST) begin
      iREN   = 1'b0;
      iaddr  = '0;
      pc_en  = 1'b0;
      accept = 1'b0;
    end
  end

  // Single-entry instruction buffer and capture counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      instr_q    <= iload;
      instr_pc_q <= pc;
      valid_q    <= 1'b1;
      count_q    <= count_q + WORD_W'(1);
      if (is_halt_op) halted_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a behavioural model predicts handshakes
// and captured words; a monitor checks each capture against the expected queue.
module tb_fetch_unit;

  localparam logic [5:0] HALT_OP = 6'h3F;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] pc;
  logic        pc_en;
  logic        redirect;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        halted;
  logic [31:0] fetch_count;

  fetch_unit #(.HALT_OP(HALT_OP)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .pc_en(pc_en), .redirect(redirect),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .dec_ready(dec_ready),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    logic [31:0] cnt;
  } cap_t;

  cap_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Model: buffer occupancy, stalled-on-decode flag, halted flag, capture count, pc.
  bit          m_valid, m_wait, m_halted;
  logic [31:0] m_count;
  logic [31:0] m_pc;
  bit          mon_resync = 1'b1;
  logic [31:0] last_count = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_wait   = 1'b0;
    m_halted = 1'b0;
    m_count  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_instr"}, instr, '0);
    chk({tag, "_instr_pc"}, instr_pc, '0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), '0);
    chk({tag, "_halted"}, 32'(halted), '0);
    chk({tag, "_fetch_count"}, fetch_count, '0);
    chk({tag, "_iREN"}, 32'(iREN), '0);
    chk({tag, "_iaddr"}, iaddr, '0);
    chk({tag, "_pc_en"}, 32'(pc_en), '0);
  endtask

  // One clock cycle: check registered state, drive inputs, check handshake, advance model.
  task automatic step(input bit ih, input logic [31:0] ld, input bit rd, input bit dr);
    bit          free, acc, ren;
    logic [31:0] cur_pc;
    logic [31:0] target;
    bit          was_halted;
    cap_t        c;
    @(negedge CLK);
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fetch_count", fetch_count, m_count);
    ihit = ih; iload = ld; redirect = rd; dec_ready = dr; pc = m_pc;
    #1;
    cur_pc     = m_pc;
    was_halted = m_halted;
    free       = !m_valid || dr;
    ren        = 1'b0;
    acc        = 1'b0;
    if (m_halted) begin
      if (dr) m_valid = 1'b0;
    end else if (m_wait) begin
      if (rd || dr) begin
        m_valid = 1'b0;
        m_wait  = 1'b0;
      end
    end else begin
      ren = !rd;
      acc = ih && !rd && free;
      if (rd) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_count = m_count + 32'd1;
        c.word = ld; c.addr = cur_pc; c.cnt = m_count;
        exp_q.push_back(c);
        if (ld[31:26] == HALT_OP) m_halted = 1'b1;
      end else if (ih) m_wait = 1'b1;
      else if (dr) m_valid = 1'b0;
    end
    chk("iREN", 32'(iREN), 32'(ren));
    chk("iaddr", iaddr, ren ? cur_pc : 32'd0);
    chk("pc_en", 32'(pc_en), 32'(acc));
    target = $urandom;
    target[1:0] = 2'b00;
    if (acc) m_pc = cur_pc + 32'd4;
    else if (rd && !was_halted) m_pc = target;
  endtask

  task automatic rand_step(input bit allow_halt);
    logic [31:0] w;
    w = $urandom;
    if (allow_halt && $urandom_range(0, 40) == 0) w[31:26] = HALT_OP;
    else if (w[31:26] == HALT_OP) w[31:26] = 6'h01;
    step($urandom_range(0, 3) != 0, w, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
  endtask

  // Called right after step(): reset lands before the pending edge, cancelling its capture.
  task automatic do_reset(input string tag);
    mon_resync = 1'b1;
    exp_q.delete();
    ihit = 1'b1;
    #1 nRST = 1'b0;
    #1 chk_all_zero(tag);
    @(negedge CLK);
    ihit = 1'b0; redirect = 1'b0; dec_ready = 1'b0;
    nRST = 1'b1;
    model_reset();
  endtask

  // Monitor: every change of fetch_count must match the next expected capture.
  initial begin
    cap_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (mon_resync) begin
        last_count = fetch_count;
        mon_resync = 1'b0;
      end else if (fetch_count !== last_count) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_capture", fetch_count, last_count);
        end else begin
          e = exp_q.pop_front();
          chk("cap_instr", instr, e.word);
          chk("cap_instr_pc", instr_pc, e.addr);
          chk("cap_count", fetch_count, e.cnt);
          chk("cap_valid", 32'(instr_valid), 32'd1);
        end
        last_count = fetch_count;
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("missed_capture", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    ihit = 1'b1; iload = '0; redirect = 1'b0; dec_ready = 1'b0; pc = '0;
    model_reset();
    m_pc = '0;
    #6 chk_all_zero("por");
    @(negedge CLK);
    ihit = 1'b0;
    nRST = 1'b1;

    // Streaming at one instruction per cycle from pc 0.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h2001_0001, 1'b0, 1'b1);
    @(posedge CLK);
    #1 chk("stream_count", fetch_count, 32'd4);
    chk("stream_valid", 32'(instr_valid), 32'd1);

    // Stall on a full buffer, then drain.
    step(1'b1, 32'h1111_0000, 1'b0, 1'b0);
    step(1'b1, 32'h2222_0000, 1'b0, 1'b0);
    step(1'b1, 32'h3333_0000, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h4444_0000, 1'b0, 1'b1);

    // Redirect discards a hit and the buffered word.
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Halt opcode under redirect is dropped; without redirect it halts the unit.
    do_reset("rst_a");
    step(1'b1, 32'hFC00_0000, 1'b1, 1'b1);
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1234_5678, i[0], 1'b0);
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
    @(posedge CLK);
    #1 chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_consumed", 32'(instr_valid), 32'd0);

    // Reset while stalled with a word buffered.
    do_reset("rst_b");
    step(1'b1, 32'h0A0A_0A0A, 1'b0, 1'b1);
    step(1'b1, 32'h0B0B_0B0B, 1'b0, 1'b0);
    step(1'b1, 32'h0C0C_0C0C, 1'b0, 1'b0);
    do_reset("rst_hold");
    step(1'b1, 32'h0D0D_0D0D, 1'b0, 1'b1);

    // Counter wrap from all-ones.
    do_reset("rst_c");
    @(negedge CLK);
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    m_count = 32'hFFFF_FFFF;
    mon_resync = 1'b1;
    step(1'b1, 32'h0E0E_0E0E, 1'b0, 1'b1);
    @(posedge CLK);
    #1 chk("count_wrap", fetch_count, 32'd0);

    // Long random run without halts, then short segments that may halt.
    for (int i = 0; i < 2000; i++) rand_step(1'b0);
    for (int s = 0; s < 6; s++) begin
      do_reset("rst_seg");
      for (int i = 0; i < 300; i++) rand_step(1'b1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
